// File: rtl/himm_axil_pkg.sv
// Shared types and helpers for the HIMM AXI4-Lite register slave.
package himm_axil_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;

   // Merge new data into an old word, one byte lane per strobe bit.
   function automatic logic [DATA_W-1:0] apply_wstrb(input logic [DATA_W-1:0] old,
                                                     input logic [DATA_W-1:0] data,
                                                     input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] res;
      res = old;
      for (int i = 0; i < int'(STRB_W); i++) begin
         if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/himm_axil_slave_regs.sv
// AXI4-Lite slave holding NUM_REGS control registers for HIMM user logic.
// Independent write and read FSMs; out-of-range word indices answer SLVERR.
module himm_axil_slave_regs
   import himm_axil_pkg::*;
#(
   parameter int unsigned C_DATA_WIDTH = 32,
   parameter int unsigned C_ADDR_WIDTH = 6,
   parameter int unsigned NUM_REGS     = 4
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_ADDR_WIDTH-1:0]         AWADDR,
   input  logic [2:0]                      AWPROT,
   input  logic                            AWVALID,
   output logic                            AWREADY,
   input  logic [C_DATA_WIDTH-1:0]         WDATA,
   input  logic [C_DATA_WIDTH/8-1:0]       WSTRB,
   input  logic                            WVALID,
   output logic                            WREADY,
   output logic [1:0]                      BRESP,
   output logic                            BVALID,
   input  logic                            BREADY,
   input  logic [C_ADDR_WIDTH-1:0]         ARADDR,
   input  logic [2:0]                      ARPROT,
   input  logic                            ARVALID,
   output logic                            ARREADY,
   output logic [C_DATA_WIDTH-1:0]         RDATA,
   output logic [1:0]                      RRESP,
   output logic                            RVALID,
   input  logic                            RREADY,
   output logic [NUM_REGS*C_DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]             reg_wr_pulse
);

   localparam int unsigned IDX_W = C_ADDR_WIDTH - 2;
   localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int unsigned BE_W  = C_DATA_WIDTH / 8;

   logic [C_DATA_WIDTH-1:0] regs [NUM_REGS];

   wr_state_t               wr_state;
   rd_state_t               rd_state;
   logic                    aw_held;
   logic                    w_held;
   logic [IDX_W-1:0]        aw_idx_q;
   logic [C_DATA_WIDTH-1:0] w_data_q;
   logic [BE_W-1:0]         w_strb_q;

   logic                    aw_hs_c;
   logic                    w_hs_c;
   logic                    ar_hs_c;
   logic                    wr_go_c;
   logic                    wr_in_range_c;
   logic                    rd_in_range_c;
   logic [IDX_W-1:0]        wr_idx_c;
   logic [IDX_W-1:0]        rd_idx_c;
   logic [SEL_W-1:0]        wr_sel_c;
   logic [SEL_W-1:0]        rd_sel_c;
   logic [C_DATA_WIDTH-1:0] wr_data_c;
   logic [BE_W-1:0]         wr_strb_c;
   logic                    unused_c;

   assign unused_c = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

   // A beat captured this cycle is used directly so commit needs no extra cycle.
   assign aw_hs_c       = AWVALID & AWREADY;
   assign w_hs_c        = WVALID & WREADY;
   assign ar_hs_c       = ARVALID & ARREADY;
   assign wr_idx_c      = aw_held ? aw_idx_q : AWADDR[C_ADDR_WIDTH-1:2];
   assign wr_data_c     = w_held ? w_data_q : WDATA;
   assign wr_strb_c     = w_held ? w_strb_q : WSTRB;
   assign wr_go_c       = (wr_state == W_IDLE) && (aw_held || aw_hs_c) && (w_held || w_hs_c);
   assign wr_in_range_c = 32'(wr_idx_c) < NUM_REGS;
   assign wr_sel_c      = SEL_W'(wr_idx_c);
   assign rd_idx_c      = ARADDR[C_ADDR_WIDTH-1:2];
   assign rd_in_range_c = 32'(rd_idx_c) < NUM_REGS;
   assign rd_sel_c      = SEL_W'(rd_idx_c);

   // Write FSM, holding registers and register array.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_state     <= W_IDLE;
         AWREADY      <= 1'b0;
         WREADY       <= 1'b0;
         BVALID       <= 1'b0;
         BRESP        <= RESP_OKAY;
         aw_held      <= 1'b0;
         w_held       <= 1'b0;
         aw_idx_q     <= '0;
         w_data_q     <= '0;
         w_strb_q     <= '0;
         reg_wr_pulse <= '0;
         for (int k = 0; k < int'(NUM_REGS); k++) regs[k] <= '0;
      end else begin
         reg_wr_pulse <= '0;
         case (wr_state)
            W_IDLE: begin
               if (aw_hs_c) begin
                  aw_held  <= 1'b1;
                  aw_idx_q <= AWADDR[C_ADDR_WIDTH-1:2];
               end
               if (w_hs_c) begin
                  w_held   <= 1'b1;
                  w_data_q <= WDATA;
                  w_strb_q <= WSTRB;
               end
               if (wr_go_c) begin
                  wr_state <= W_RESP;
                  AWREADY  <= 1'b0;
                  WREADY   <= 1'b0;
                  BVALID   <= 1'b1;
                  if (wr_in_range_c) begin
                     regs[wr_sel_c] <= apply_wstrb(regs[wr_sel_c], wr_data_c, wr_strb_c);
                     BRESP          <= RESP_OKAY;
                     for (int k = 0; k < int'(NUM_REGS); k++)
                        reg_wr_pulse[k] <= (wr_sel_c == SEL_W'(k));
                  end else begin
                     BRESP <= RESP_SLVERR;
                  end
               end else begin
                  AWREADY <= !(aw_held || aw_hs_c);
                  WREADY  <= !(w_held || w_hs_c);
               end
            end
            W_RESP: begin
               if (BREADY) begin
                  wr_state <= W_IDLE;
                  BVALID   <= 1'b0;
                  aw_held  <= 1'b0;
                  w_held   <= 1'b0;
                  AWREADY  <= 1'b1;
                  WREADY   <= 1'b1;
               end
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   // Read FSM; sampling regs here yields the pre-write value on a same-edge commit.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rd_state <= R_IDLE;
         ARREADY  <= 1'b0;
         RVALID   <= 1'b0;
         RDATA    <= '0;
         RRESP    <= RESP_OKAY;
      end else begin
         case (rd_state)
            R_IDLE: begin
               if (ar_hs_c) begin
                  rd_state <= R_DATA;
                  ARREADY  <= 1'b0;
                  RVALID   <= 1'b1;
                  if (rd_in_range_c) begin
                     RDATA <= regs[rd_sel_c];
                     RRESP <= RESP_OKAY;
                  end else begin
                     RDATA <= '0;
                     RRESP <= RESP_SLVERR;
                  end
               end else begin
                  ARREADY <= 1'b1;
               end
            end
            R_DATA: begin
               if (RREADY) begin
                  rd_state <= R_IDLE;
                  RVALID   <= 1'b0;
                  ARREADY  <= 1'b1;
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

   for (genvar k = 0; k < int'(NUM_REGS); k++) begin : g_reg_q
      assign reg_q[C_DATA_WIDTH*k +: C_DATA_WIDTH] = regs[k];
   end

endmodule

// File: tb/tb_himm_axil_slave_regs.sv
// Randomized self-checking bench for himm_axil_slave_regs against a register-array model.
module tb_himm_axil_slave_regs;

   localparam int unsigned NREG = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [5:0]        awaddr;
   logic [2:0]        awprot;
   logic              awvalid;
   logic              awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [5:0]        araddr;
   logic [2:0]        arprot;
   logic              arvalid;
   logic              arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;
   logic [NREG*32-1:0] reg_q;
   logic [NREG-1:0]   reg_wr_pulse;

   int                n_checks = 0;
   int                n_errors = 0;
   logic [31:0]       model [NREG];

   himm_axil_slave_regs #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(6), .NUM_REGS(NREG)) dut (
      .ACLK(clk), .ARESETN(rst_n),
      .AWADDR(awaddr), .AWPROT(awprot), .AWVALID(awvalid), .AWREADY(awready),
      .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready),
      .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
      .ARADDR(araddr), .ARPROT(arprot), .ARVALID(arvalid), .ARREADY(arready),
      .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(rready),
      .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit in_range(input logic [5:0] a);
      return int'(a[5:2]) < int'(NREG);
   endfunction

   function automatic logic [1:0] exp_resp(input logic [5:0] a);
      return in_range(a) ? 2'b00 : 2'b10;
   endfunction

   task automatic check_regs(input string tag);
      for (int k = 0; k < int'(NREG); k++) check(tag, 64'(reg_q[32*k +: 32]), 64'(model[k]));
   endtask

   // Model update: byte-mask merge of the new word into the stored word.
   task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] mask;
      if (in_range(a)) begin
         mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
         model[a[5:2]] = (model[a[5:2]] & ~mask) | (d & mask);
      end
   endtask

   // Drive one write with per-channel start delays; all activity at negedge.
   task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int hold_b, input bit rst_mid);
      bit          aw_done = 0;
      bit          w_done  = 0;
      int          t       = 0;
      logic [1:0]  rsp;
      logic [NREG-1:0] pulse;
      awaddr = a; wdata = d; wstrb = s; bready = 1'b0;
      while (!(aw_done && w_done) && t < 50) begin
         awvalid = !aw_done && (t >= aw_dly);
         wvalid  = !w_done && (t >= w_dly);
         check("bvalid_before_commit", 64'(bvalid), 64'd0);
         if (aw_done) check("awready_after_capture", 64'(awready), 64'd0);
         if (w_done)  check("wready_after_capture", 64'(wready), 64'd0);
         if (awvalid && awready) aw_done = 1;
         if (wvalid && wready)   w_done  = 1;
         @(negedge clk);
         t++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      if (!(aw_done && w_done)) begin
         check("write_handshake_timeout", 64'(t), 64'd0);
         return;
      end
      model_write(a, d, s);
      pulse = in_range(a) ? NREG'(1) << a[5:2] : '0;
      check("bvalid_latency", 64'(bvalid), 64'd1);
      check("bresp", 64'(bresp), 64'(exp_resp(a)));
      check("wr_pulse", 64'(reg_wr_pulse), 64'(pulse));
      check_regs("reg_q_after_write");
      rsp = bresp;
      if (rst_mid) begin
         #2 rst_n = 1'b0;
         #1;
         check("bvalid_async_reset", 64'(bvalid), 64'd0);
         for (int k = 0; k < int'(NREG); k++) model[k] = '0;
         check_regs("reg_q_async_reset");
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         return;
      end
      for (int i = 0; i < hold_b; i++) begin
         @(negedge clk);
         check("bvalid_hold", 64'(bvalid), 64'd1);
         check("bresp_hold", 64'(bresp), 64'(rsp));
         check("wr_pulse_one_cycle", 64'(reg_wr_pulse), 64'd0);
         check("awready_in_resp", 64'({awready, wready}), 64'd0);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check("bvalid_cleared", 64'(bvalid), 64'd0);
      check("ready_after_bresp", 64'({awready, wready}), 64'b11);
   endtask

   task automatic axi_read(input logic [5:0] a, input int hold_r);
      int          t = 0;
      logic [31:0] exp_d;
      logic [33:0] snap;
      araddr  = a;
      arvalid = 1'b1;
      rready  = 1'b0;
      while (!arready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!arready) begin
         check("read_handshake_timeout", 64'(t), 64'd0);
         arvalid = 1'b0;
         return;
      end
      exp_d = in_range(a) ? model[a[5:2]] : 32'd0;
      @(negedge clk);
      arvalid = 1'b0;
      check("rvalid_latency", 64'(rvalid), 64'd1);
      check("rdata", 64'(rdata), 64'(exp_d));
      check("rresp", 64'(rresp), 64'(exp_resp(a)));
      snap = {rresp, rdata};
      for (int i = 0; i < hold_r; i++) begin
         @(negedge clk);
         check("rvalid_hold", 64'(rvalid), 64'd1);
         check("rdata_rresp_hold", 64'({rresp, rdata}), 64'(snap));
         check("arready_in_data", 64'(arready), 64'd0);
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      check("rvalid_cleared", 64'(rvalid), 64'd0);
   endtask

   initial begin
      logic [5:0]  ra;
      logic [31:0] rd;
      logic [3:0]  rs;
      rst_n = 1'b0;
      awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
      bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
      for (int k = 0; k < int'(NREG); k++) model[k] = '0;

      repeat (3) @(negedge clk);
      check("reset_readies", 64'({awready, wready, arready}), 64'd0);
      check("reset_valids", 64'({bvalid, rvalid}), 64'd0);
      check("reset_resp_data", 64'({bresp, rresp, rdata}), 64'd0);
      check("reset_pulse", 64'(reg_wr_pulse), 64'd0);
      check_regs("reset_reg_q");
      rst_n = 1'b1;
      @(negedge clk);
      check("readies_after_reset", 64'({awready, wready, arready}), 64'b111);

      for (int k = 0; k < 4; k++) axi_write(6'(4*k), 32'(k+1), 4'hF, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) axi_read(6'(4*k), 0);

      axi_write(6'h04, 32'h11223344, 4'hF, 0, 0, 0, 0);
      axi_write(6'h04, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 0);
      axi_read(6'h04, 0);

      axi_write(6'h08, 32'hCAFE0001, 4'hF, 3, 0, 0, 0);
      axi_read(6'h08, 0);
      axi_write(6'h0C, 32'hBEEF0002, 4'hF, 0, 3, 0, 0);
      axi_read(6'h0C, 0);

      axi_write(6'h20, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
      axi_read(6'h20, 0);

      axi_write(6'h00, 32'h5A5A1234, 4'hF, 1, 2, 5, 0);
      axi_read(6'h00, 5);

      for (int n = 0; n < 40; n++) begin
         ra = 6'($urandom_range(0, 15) << 2);
         rd = $urandom;
         rs = 4'($urandom);
         axi_write(ra, rd, rs, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 0);
         ra = 6'($urandom_range(0, 15) << 2);
         axi_read(ra, $urandom_range(0, 2));
      end

      axi_write(6'h04, 32'h01020304, 4'hF, 0, 0, 0, 1);
      for (int k = 0; k < 4; k++) axi_read(6'(4*k), 0);
      axi_write(6'h08, 32'h77665544, 4'hF, 0, 1, 0, 0);
      axi_read(6'h08, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/himm_axil_slave_regs.md
# himm_axil_slave_regs

AXI4-Lite slave register file for the HIMM module: responds to a single AXI4-Lite master (the AXI VIP master in block-design benches, the processor interconnect in the system build). It holds NUM_REGS 32-bit control registers, exports them to HIMM user logic, and accepts write address and write data on independent channels. Out-of-range accesses return SLVERR.

## Interface
- C_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_ADDR_WIDTH, 6, AXI address width; word index = ADDR[C_ADDR_WIDTH-1:2].
- NUM_REGS, 4, implemented registers at byte offsets 0x0, 0x4, …; must be ≤ 2^(C_ADDR_WIDTH-2).
- ACLK  in  1  sole clock; all logic on the rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  C_ADDR_WIDTH/3/1/1  write address channel; AWPROT ignored.
- WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
- BRESP/BVALID/BREADY  out/out/in  2/1/1  write response.
- ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  C_ADDR_WIDTH/3/1/1  read address; ARPROT ignored.
- RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data.
- reg_q  out  NUM_REGS*32  register contents; register k at [32k+31:32k].
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse in the cycle after register k is updated.

## Operation
- Reset: all registers 0; AWREADY, WREADY, ARREADY, BVALID, RVALID 0; BRESP, RRESP, RDATA 0; reg_wr_pulse 0; both FSMs in IDLE.
- Write FSM, states W_IDLE, W_RESP.
  - W_IDLE: AWREADY = 1 until AW captured; WREADY = 1 until W captured. Channels accepted in either order, or in the same cycle; each captured beat held in a holding register.
  - When both are held (including both in one cycle): commit on the next edge. In-range index: byte lanes with WSTRB set are updated, others kept; BRESP = OKAY (2'b00). Out-of-range: no register change; BRESP = SLVERR (2'b10). Enter W_RESP with BVALID = 1.
  - W_RESP: AWREADY = WREADY = 0; BVALID and BRESP held stable until BREADY; on handshake return to W_IDLE and clear the holds.
- Read FSM, states R_IDLE, R_DATA.
  - R_IDLE: ARREADY = 1. On handshake, latch RDATA (register value, or 0 if out of range) and RRESP (OKAY/SLVERR); enter R_DATA with RVALID = 1.
  - R_DATA: ARREADY = 0; RDATA and RRESP stable until RREADY; then R_IDLE.
- Read and write FSMs are fully independent. If a read captures the register in the same edge that a write commits to it, the read returns the pre-write value.
- AWREADY, WREADY, and ARREADY are registered: 0 during reset, 1 from the first edge after ARESETN deasserts.

## Timing
- AW and W handshakes in cycle N → register updated and BVALID high at N+1. With split channels, latency counts from the later handshake.
- AR handshake in cycle N → RVALID high with valid RDATA at N+1.
- With BREADY and RREADY held high, each channel sustains one transaction every 2 cycles.
- reg_q changes at the commit edge. reg_wr_pulse is high for exactly one cycle, aligned with BVALID rising.
- Reset mid-transaction: all state is dropped immediately (asynchronous). Any pending response is lost, and no partial register write occurs.

## Structure
- Package himm_axil_pkg:
  - RESP_OKAY, RESP_SLVERR constants;
  - wr_state_t {W_IDLE, W_RESP} and rd_state_t {R_IDLE, R_DATA};
  - an apply_wstrb(old, data, strb) function.
- No sub-module. The register array, the two FSMs, and the holding registers are kept in one module.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read back → RDATA 0x1..0x4, all responses OKAY, reg_wr_pulse seen once per register.
- Write 0xAABBCCDD to 0x4 with WSTRB = 4'b0101 over prior 0x11223344 → read 0x11BB33DD.
- Present W three cycles before AW; then repeat with AW first → BVALID exactly 1 cycle after the later handshake; data correct.
- Write and read at 0x20 (out of range) → BRESP = 2'b10, RRESP = 2'b10, RDATA = 0, reg_q unchanged.
- Hold BREADY/RREADY low for 5 cycles → BVALID/RVALID, BRESP/RRESP, and RDATA stable; AWREADY, WREADY, and ARREADY stay 0 until each response handshake completes.
- Assert ARESETN low while in W_RESP → BVALID drops immediately, all registers read 0 after reset, and a new write completes normally.
